sar_search4: RTL and testbench

- Successive-approximation search controller.
- Drives a probe word into a combinational magnitude comparator (probe on the comparator's A side, unknown target on the B side) and consumes its less/equal/more outputs.
- Binary-searches the unknown target value, MSB first, with early exit on equality.
- Sits on the driving side of the 4-bit comparator interface; used for threshold tracking and calibration.

---
 rtl/sar_search4.sv | 125 ++++++++++++
 tb/tb_sar_search4.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sar_search4.sv
// Successive-approximation search controller: binary-searches an unknown target
// through an external magnitude comparator, MSB first. Optional: SAR_STEP_COUNT_EN adds a compare counter.
module sar_search4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_l,
  input  logic             cmp_e,
  input  logic             cmp_m,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
`ifdef SAR_STEP_COUNT_EN
  , output logic [$clog2(WIDTH+2)-1:0] steps
`endif
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, VERIFY} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [WIDTH-1:0] probe_dec;
  logic            legal;
  logic            finish;
  logic            accept;

`ifdef SAR_STEP_COUNT_EN
  logic [$clog2(WIDTH+2)-1:0] cnt;
`endif

  // Exactly one of the three comparator lines may be high.
  assign legal  = (cmp_l ^ cmp_e ^ cmp_m) & ~(cmp_l & cmp_e & cmp_m);
  // The done cycle is already IDLE, so start is masked there to keep one search per IDLE entry.
  assign accept = (state == IDLE) && start && !done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SEARCH;
      SEARCH: begin
        if (!legal || cmp_e)  state_nxt = IDLE;
        else if (idx == '0)   state_nxt = VERIFY;
      end
      VERIFY:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    finish = ((state == SEARCH) && (!legal || cmp_e)) || (state == VERIFY);
  end

  // Apply the current bit decision and, unless on the LSB, trial-set the next bit.
  always_comb begin
    probe_dec = probe;
    if (cmp_m) probe_dec[idx] = 1'b0;
    if (idx != '0) probe_dec[idx - IW'(1)] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      probe  <= '0;
      idx    <= IW'(WIDTH-1);
      done   <= 1'b0;
      result <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
`ifdef SAR_STEP_COUNT_EN
      cnt    <= '0;
      steps  <= '0;
`endif
    end else begin
      done <= finish;
      case (state)
        IDLE: begin
          if (accept) begin
            probe <= {1'b1, {(WIDTH-1){1'b0}}};
            idx   <= IW'(WIDTH-1);
`ifdef SAR_STEP_COUNT_EN
            cnt   <= '0;
`endif
          end
        end
        SEARCH: begin
          if (finish) begin
            result <= probe;
            found  <= legal;
            err    <= !legal;
            probe  <= '0;
            idx    <= IW'(WIDTH-1);
          end else begin
            probe <= probe_dec;
            if (idx != '0) idx <= idx - IW'(1);
          end
        end
        VERIFY: begin
          result <= probe;
          found  <= legal & cmp_e;
          err    <= !legal;
          probe  <= '0;
          idx    <= IW'(WIDTH-1);
        end
        default: probe <= '0;
      endcase
`ifdef SAR_STEP_COUNT_EN
      if (state != IDLE) cnt <= cnt + 1'b1;
      if (finish) steps <= cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_sar_search4.sv
// Directed bench for sar_search4: behavioural comparator, expected probe queue, hand-computed results.
module tb_sar_search4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cmp_l, cmp_e, cmp_m;
  logic [3:0] probe;
  logic       busy, done, found, err;
  logic [3:0] result;
`ifdef SAR_STEP_COUNT_EN
  logic [2:0] steps;
`endif

  logic [3:0] target;
  logic       inj_en;
  logic [3:0] inj_val;
  logic [2:0] inj_code;

  logic [3:0] exp_q[$];
  logic [3:0] last_res;
  logic       last_found, last_err;
  int total = 0;
  int bad   = 0;

  sar_search4 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_l(cmp_l), .cmp_e(cmp_e), .cmp_m(cmp_m),
    .probe(probe), .busy(busy), .done(done),
    .result(result), .found(found), .err(err)
`ifdef SAR_STEP_COUNT_EN
    , .steps(steps)
`endif
  );

  always #5 clk = ~clk;

  // Comparator model: probe on A, target on B, with an optional forced code on one probe value.
  always_comb begin
    if (inj_en && probe == inj_val) begin
      {cmp_l, cmp_e, cmp_m} = inj_code;
    end else begin
      cmp_l = (probe < target);
      cmp_e = (probe == target);
      cmp_m = (probe > target);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Entered just after the edge that accepted start; checks each probe, the done cycle and the cycle after.
  task automatic follow(input logic [3:0] res, input logic fnd, input logic er);
    int n;
    n = exp_q.size();
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check("probe", probe, exp_q.pop_front());
      check("busy_in_search", busy, 1);
      check("no_early_done", done, 0);
      check("result_held", {last_err, last_found, result}, {err, found, last_res});
      @(posedge clk);
    end
    @(negedge clk);
    check("done", done, 1);
    check("busy_at_done", busy, 0);
    check("result", result, res);
    check("found", found, fnd);
    check("err", err, er);
`ifdef SAR_STEP_COUNT_EN
    check("steps", steps, n);
`endif
    last_res = res; last_found = fnd; last_err = er;
    @(posedge clk); #1;
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("idle_probe", probe, 0);
  endtask

  task automatic do_search(input logic [3:0] tgt, input logic hold,
                           input logic [3:0] res, input logic fnd, input logic er);
    target = tgt;
    start  = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    follow(res, fnd, er);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; target = '0;
    inj_en = 1'b0; inj_val = '0; inj_code = '0;
    last_res = '0; last_found = 1'b0; last_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_probe", probe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", {err, found, result}, 0);
`ifdef SAR_STEP_COUNT_EN
    check("rst_steps", steps, 0);
`endif

    exp_q = '{4'd8, 4'd12, 4'd10, 4'd11};
    do_search(4'd11, 1'b0, 4'd11, 1'b1, 1'b0);

    exp_q = '{4'd8, 4'd4, 4'd2, 4'd1, 4'd0};
    do_search(4'd0, 1'b0, 4'd0, 1'b1, 1'b0);

    exp_q = '{4'd8, 4'd12, 4'd14, 4'd15};
    do_search(4'd15, 1'b0, 4'd15, 1'b1, 1'b0);

    // Illegal l+m code on the second probe ends the search with err.
    inj_en = 1'b1; inj_val = 4'd12; inj_code = 3'b101;
    exp_q = '{4'd8, 4'd12};
    do_search(4'd11, 1'b0, 4'd12, 1'b0, 1'b1);
    inj_en = 1'b0;

    exp_q = '{4'd8, 4'd12, 4'd10, 4'd11};
    do_search(4'd11, 1'b0, 4'd11, 1'b1, 1'b0);

    // Reset in cycle 2 of a search, then a fresh search for 5.
    target = 4'd5;
    start  = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("pre_rst_probe", probe, 8);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("pre_rst_probe2", probe, 4);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_probe", probe, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", {err, found, result}, 0);
    last_res = '0; last_found = 1'b0; last_err = 1'b0;
    exp_q = '{4'd8, 4'd4, 4'd6, 4'd5};
    do_search(4'd5, 1'b0, 4'd5, 1'b1, 1'b0);

    // start held high: ignored while busy and at done, accepted the cycle after done.
    exp_q = '{4'd8, 4'd12, 4'd10, 4'd11};
    do_search(4'd11, 1'b1, 4'd11, 1'b1, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    exp_q = '{4'd8, 4'd4, 4'd6, 4'd5};
    target = 4'd5;
    follow(4'd5, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
